// File: rtl/argmax_sequencer.sv
// argmax_sequencer
//   Sequential argmax over one frame of NUM_CLASSES signed scores. A frame
//   is captured through a valid/ready handshake and scanned one class per
//   cycle with a single comparator. The result (index, score, 7-segment
//   digit) is returned through a second valid/ready handshake.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     frame present on data
//   in_ready     block can accept a frame (IDLE)
//   data         packed scores, class k at [FFN_OUT_WIDTH*(k+1)-1 : FFN_OUT_WIDTH*k]
//   out_valid    result available (DONE)
//   out_ready    consumer accepts result
//   class_idx    winning class (lowest index on ties)
//   max_score    winning score
//   hex          active-low segments {g,f,e,d,c,b,a} showing class_idx
//   busy         high in SCAN or DONE
//   result_count results consumed, modulo 256
module argmax_sequencer #(
  parameter int FFN_OUT_WIDTH = 16,
  parameter int NUM_CLASSES   = 10,
  parameter int IDX_WIDTH     = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FFN_OUT_WIDTH*NUM_CLASSES-1:0] data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IDX_WIDTH-1:0]                 class_idx,
  output logic signed [FFN_OUT_WIDTH-1:0]      max_score,
  output logic [6:0]                           hex,
  output logic                                 busy,
  output logic [7:0]                           result_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [6:0]           HEX_DASH = 7'b0111111;

  state_t state, state_next;

  logic signed [FFN_OUT_WIDTH-1:0] score_p0 [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]            scan_idx_p1;
  logic [IDX_WIDTH-1:0]            best_idx_p1;
  logic signed [FFN_OUT_WIDTH-1:0] best_val_p1;

  logic signed [FFN_OUT_WIDTH-1:0] cand;
  logic                            take_cand;
  logic [IDX_WIDTH-1:0]            best_idx_nxt;
  logic signed [FFN_OUT_WIDTH-1:0] best_val_nxt;
  logic                            accept;
  logic                            last_step;
  logic                            consume;

  function automatic logic [6:0] seg_digit(input logic [IDX_WIDTH-1:0] idx);
    logic [6:0] seg;
    case (32'(idx))
      32'd0:   seg = 7'b1000000;
      32'd1:   seg = 7'b1111001;
      32'd2:   seg = 7'b0100100;
      32'd3:   seg = 7'b0110000;
      32'd4:   seg = 7'b0011001;
      32'd5:   seg = 7'b0010010;
      32'd6:   seg = 7'b0000010;
      32'd7:   seg = 7'b1111000;
      32'd8:   seg = 7'b0000000;
      32'd9:   seg = 7'b0011000;
      default: seg = 7'b0000110;
    endcase
    return seg;
  endfunction

  // Shared comparator: strict greater-than keeps the lowest index on ties.
  always_comb begin
    cand         = score_p0[scan_idx_p1];
    take_cand    = cand > best_val_p1;
    best_idx_nxt = take_cand ? scan_idx_p1 : best_idx_p1;
    best_val_nxt = take_cand ? cand : best_val_p1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    last_step  = 1'b0;
    consume    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_next = SCAN;
      end
      SCAN: begin
        last_step = (scan_idx_p1 == LAST_IDX);
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        consume   = out_ready;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0/p1: frame capture and running best (datapath, no reset; every
  // field is reloaded on accept before it is used).
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < NUM_CLASSES; k++)
        score_p0[k] <= $signed(data[FFN_OUT_WIDTH*k +: FFN_OUT_WIDTH]);
      best_idx_p1 <= '0;
      best_val_p1 <= $signed(data[FFN_OUT_WIDTH-1:0]);
      scan_idx_p1 <= IDX_WIDTH'(1);
    end else if (state == SCAN) begin
      best_idx_p1 <= best_idx_nxt;
      best_val_p1 <= best_val_nxt;
      scan_idx_p1 <= scan_idx_p1 + IDX_WIDTH'(1);
    end
  end

  // Result stage: loaded on the DONE-entry edge, held until the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      class_idx    <= '0;
      max_score    <= '0;
      hex          <= HEX_DASH;
      result_count <= '0;
    end else begin
      if (last_step) begin
        class_idx <= best_idx_nxt;
        max_score <= best_val_nxt;
        hex       <= seg_digit(best_idx_nxt);
      end
      if (consume) result_count <= result_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_argmax_sequencer.sv
module tb_argmax_sequencer;
  localparam int W  = 16;
  localparam int N  = 10;
  localparam int IW = 4;
  localparam logic [6:0] HEX_DASH = 7'b0111111;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [W*N-1:0]   data = '0;
  logic             in_ready, out_valid, busy;
  logic [IW-1:0]    class_idx;
  logic signed [W-1:0] max_score;
  logic [6:0]       hex;
  logic [7:0]       result_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  argmax_sequencer #(.FFN_OUT_WIDTH(W), .NUM_CLASSES(N), .IDX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_score(max_score), .hex(hex), .busy(busy),
    .result_count(result_count)
  );

  always #5 clock = ~clock;

  // ---------------- reference model (transaction/timeline level) ----------
  function automatic logic [6:0] seg_ref(input logic [IW-1:0] idx);
    case (int'(idx))
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b0000110;
    endcase
  endfunction

  function automatic int ref_max(input logic [W*N-1:0] d);
    int mx = -(1 << 30);
    for (int k = 0; k < N; k++)
      if (int'($signed(d[W*k +: W])) > mx) mx = int'($signed(d[W*k +: W]));
    return mx;
  endfunction

  function automatic logic [IW-1:0] ref_idx(input logic [W*N-1:0] d);
    int mx = ref_max(d);
    for (int k = 0; k < N; k++)
      if (int'($signed(d[W*k +: W])) == mx) return IW'(k);
    return '0;
  endfunction

  function automatic logic [W-1:0] ref_val(input logic [W*N-1:0] d);
    return W'(ref_max(d));
  endfunction

  logic          m_pending = 1'b0;
  int            m_left = 0;
  logic [IW-1:0] m_idx = '0, m_nidx = '0;
  logic [W-1:0]  m_val = '0, m_nval = '0;
  logic [6:0]    m_hex = HEX_DASH;
  logic [7:0]    m_count = '0;
  int            m_consumed = 0;
  int            m_accepts = 0;
  int            m_acc_cyc = 0;

  // A frame is pending from accept until consumed; its result appears N-1
  // edges after accept and is consumed on the first later edge with out_ready.
  initial begin : model_proc
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      if (reset) begin
        m_pending = 1'b0; m_left = 0; m_idx = '0; m_val = '0;
        m_hex = HEX_DASH; m_count = '0;
      end else if (!m_pending) begin
        if (in_valid) begin
          m_nidx = ref_idx(data);
          m_nval = ref_val(data);
          m_pending = 1'b1;
          m_left = N - 1;
          m_accepts++;
          m_acc_cyc = cyc;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_idx = m_nidx; m_val = m_nval; m_hex = seg_ref(m_nidx);
        end
      end else if (out_ready) begin
        m_pending = 1'b0;
        m_count = m_count + 8'd1;
        m_consumed++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  logic prev_ov = 1'b0;
  int   n_ov_rise = 0;

  initial begin : cmp_proc
    logic [37:0] got_v, exp_v;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        got_v = {in_ready, out_valid, busy, class_idx, max_score, hex, result_count};
        if (reset) exp_v = {1'b1, 1'b0, 1'b0, 4'd0, 16'd0, HEX_DASH, 8'd0};
        else       exp_v = {!m_pending, m_pending && (m_left == 0), m_pending,
                            m_idx, m_val, m_hex, m_count};
        n_tests++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_model cyc=%0d got=%h expected=%h", cyc, got_v, exp_v);
        end
        if (out_valid === 1'b1 && !prev_ov && !reset) begin
          n_ov_rise++;
          n_tests++;
          if (cyc - m_acc_cyc != N - 1) begin
            n_fail++;
            $display("FAIL latency cyc=%0d got=%0d expected=%0d", cyc, cyc - m_acc_cyc, N - 1);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- helpers ----------------
  logic [W-1:0] sc [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W*N-1:0] rand_data(input int mode);
    logic [W*N-1:0] d;
    logic [W-1:0]   v;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: v = W'($urandom);
        1: v = W'($urandom_range(0, 3)) - W'(2);
        default: begin
          case ($urandom_range(0, 3))
            0: v = 16'h8000;
            1: v = 16'h7FFF;
            2: v = 16'h0000;
            default: v = 16'hFFFF;
          endcase
        end
      endcase
      d[W*k +: W] = v;
    end
    return d;
  endfunction

  task automatic send_frame(input string name);
    int a0;
    a0 = m_accepts;
    for (int k = 0; k < N; k++) data[W*k +: W] = sc[k];
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (m_accepts != a0) begin
        in_valid = 1'b0;
        data = rand_data(0);   // source may change data after the accept edge
        return;
      end
    end
    in_valid = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL %s_accept_timeout got=no_accept expected=accept", name);
  endtask

  task automatic wait_ov(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s_timeout got=out_valid_low expected=out_valid_high", name);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main_proc
    int acc;
    int c0, r0;
    logic done;

    // Reset then idle
    reset = 1'b1;
    @(posedge clock); #1 chk_en = 1'b1;
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hex", hex, 7'b0111111);
    chk("rst_count", result_count, 0);

    // Distinct max at class 7
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) sc[k] = W'(k * 10);
    sc[7] = 16'd500;
    send_frame("distinct");
    acc = cyc;
    wait_ov("distinct");
    chk("distinct_latency", cyc - acc, 9);
    chk("distinct_idx", class_idx, 7);
    chk("distinct_score", $unsigned(max_score), 16'd500);
    chk("distinct_hex", hex, 7'b1111000);
    @(negedge clock);
    chk("distinct_count", result_count, 1);
    chk("distinct_ov_fall", out_valid, 0);

    // Negative scores with a tie: lowest index wins
    for (int k = 0; k < N; k++) sc[k] = 16'hFFFB;
    sc[3] = 16'hFFFF;
    sc[8] = 16'hFFFF;
    send_frame("tie");
    wait_ov("tie");
    chk("tie_idx", class_idx, 3);
    chk("tie_score", $unsigned(max_score), 16'hFFFF);
    chk("tie_hex", hex, 7'b0110000);
    @(negedge clock);

    // Backpressure with a second frame waiting upstream
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      sc[k] = W'($urandom);
      if (sc[k] == 16'h7FFF) sc[k] = 16'h0000;
    end
    sc[0] = 16'h7FFF;
    send_frame("bp");
    wait_ov("bp");
    for (int k = 0; k < N; k++) data[W*k +: W] = 16'd1;
    data[W*5 +: W] = 16'd1000;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("bp_hold", {out_valid, in_ready, busy, class_idx, max_score},
          {1'b1, 1'b0, 1'b1, 4'd0, 16'h7FFF});
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release0", {out_valid, in_ready}, 2'b10);
    @(negedge clock);
    chk("bp_release1", {out_valid, in_ready}, 2'b01);
    @(negedge clock);
    chk("bp_accept", {in_ready, busy}, 2'b01);
    in_valid = 1'b0;
    data = rand_data(0);
    wait_ov("bp2");
    chk("bp2_idx", class_idx, 5);
    chk("bp2_score", $unsigned(max_score), 16'd1000);
    @(negedge clock);

    // Reset mid-scan
    for (int k = 0; k < N; k++) sc[k] = W'($urandom);
    send_frame("midrst");
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_ctrl", {in_ready, out_valid, busy}, 3'b100);
    chk("midrst_idx", class_idx, 0);
    chk("midrst_score", $unsigned(max_score), 0);
    chk("midrst_hex", hex, 7'b0111111);
    chk("midrst_count", result_count, 0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    for (int k = 0; k < N; k++) sc[k] = W'(-100 + k * 7);
    send_frame("after_rst");
    wait_ov("after_rst");
    chk("after_rst_idx", class_idx, 9);
    chk("after_rst_hex", hex, 7'b0011000);
    chk("after_rst_score", $unsigned(max_score), 16'hFFDB);
    @(negedge clock);

    // Counter wrap: 256 back-to-back frames
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    c0 = m_consumed;
    r0 = n_ov_rise;
    out_ready = 1'b1;
    in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      data = rand_data(i % 3);
      @(posedge clock); #1;
      if (m_consumed - c0 >= 256) done = 1'b1;
    end
    in_valid = 1'b0;
    chk("wrap_done", done, 1);
    @(negedge clock);
    chk("wrap_count", result_count, 0);
    chk("wrap_frames", n_ov_rise - r0, 256);

    // Random traffic with occasional asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      reset     = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      data      = rand_data(int'($urandom_range(0, 2)));
    end
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/argmax_sequencer.md
# argmax_sequencer

Sequential argmax controller for the classifier output layer. It accepts one frame of NUM_CLASSES FFN scores through a valid/ready handshake and scans them one class per cycle with a single shared comparator. It returns the winning class index and score through a second valid/ready handshake, and drives the 7-segment digit for the board display. It sits between the final FFN layer and the display/host readout, and replaces the wide parallel comparator tree.

## Interface
- FFN_OUT_WIDTH, 16: width of one class score, two's-complement signed.
- NUM_CLASSES, 10: number of scores per frame. Legal range 2..16.
- IDX_WIDTH, 4: width of class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  frame present on data.
- in_ready  out  1  block can accept a frame.
- data  in  FFN_OUT_WIDTH*NUM_CLASSES  packed scores; class k at bits [FFN_OUT_WIDTH*(k+1)-1 : FFN_OUT_WIDTH*k].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- class_idx  out  IDX_WIDTH  winning class.
- max_score  out  FFN_OUT_WIDTH  winning score.
- hex  out  7  active-low segments {g,f,e,d,c,b,a} for class_idx.
- busy  out  1  high in SCAN or DONE.
- result_count  out  8  number of results consumed, modulo 256.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: capture data into the internal score register, set best_idx=0, best_val=score[0], scan_idx=1, and go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle: if score[scan_idx] > best_val (signed, strict), load best_idx=scan_idx and best_val=score[scan_idx].
  - Then increment scan_idx.
  - The edge that processes scan_idx=NUM_CLASSES-1 also transitions to DONE.
- Ties: strict greater-than, so the lowest index wins.
- data and in_valid are ignored outside IDLE. The captured copy is used, so the source may change data after the accept edge.
- Register updates on the DONE-entry edge:
  - class_idx and max_score load the final best values.
  - hex loads the digit pattern.
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000. Indices 10..15 display 0000110 ("E").
- DONE:
  - out_valid=1; class_idx and max_score are stable.
  - When out_ready=1 at an edge: go to IDLE and increment result_count (wraps 255 to 0).
- class_idx, max_score and hex hold their last values after the handshake, until the next DONE entry.
- busy = (state != IDLE).

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - class_idx=0, max_score=0, result_count=0.
  - hex=0111111 (dash).
- Latency: frame accepted at edge k; out_valid rises after edge k+NUM_CLASSES-1 (9 cycles for 10 classes).
- out_valid falls after the edge where out_ready=1 is sampled. in_ready rises on that same edge.
- Minimum frame period is NUM_CLASSES+1 cycles with out_ready held high. in_ready is never high in the same cycle as out_valid.
- out_ready already high on DONE entry: the result is held for exactly one cycle.
- out_ready held low: DONE is held indefinitely with outputs stable. No frame is lost; upstream stalls on in_ready=0.
- Reset asserted mid-SCAN or in DONE: the partial result is discarded, all outputs take their reset values, and result_count is not incremented.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset then idle: assert reset for 3 cycles, release -> in_ready=1, out_valid=0, hex=0111111, result_count=0.
- Distinct max: scores k*10 for k=0..9, except class 7 = 500; out_ready high -> out_valid exactly 9 cycles after accept, class_idx=7, max_score=500, hex=1111000, result_count=1.
- Negative and tie: all scores -5, except classes 3 and 8 = -1 -> class_idx=3, max_score=-1 (0xFFFF), hex=0110000.
- Backpressure: frame with max at class 0 = 0x7FFF, out_ready low for 20 cycles -> out_valid held, outputs stable, in_ready=0. A second frame presented during the stall is not accepted until 1 cycle after out_ready rises.
- Reset mid-scan: accept frame, assert reset 4 cycles later -> all outputs at reset values, result_count=0. A following frame with max at class 9 gives class_idx=9, hex=0011000.
- Counter wrap: 256 back-to-back frames -> result_count returns to 0, and every frame shows latency 9.
